// File: rtl/access_arbiter.sv
// Two-requester access arbiter: profile-ranked grants with bounded session
// length, a one-cycle release gap between grants and sticky timeout flags.
module access_arbiter #(
  parameter int SESSION_MAX = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] PRF_A,
  input  logic       REQ_A,
  input  logic [2:0] PRF_B,
  input  logic       REQ_B,
  output logic       GNT_A,
  output logic       GNT_B,
  output logic       DENY_A,
  output logic       DENY_B,
  output logic       TOUT_A,
  output logic       TOUT_B,
  output logic       BUSY,
  output logic [2:0] OWNER_PRF,
  output logic [7:0] CNT,
  output logic [1:0] dbg_state
);

  // Handshake: REQ_x is a level request sampled every rising edge; GNT_x is
  // the registered answer and stays high until the owner drops REQ_x, loses
  // its permission, or the session reaches SESSION_MAX cycles.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(SESSION_MAX);

  state_t state;
  logic   last_b;
  logic   perm_a, perm_b;
  logic   elig_a, elig_b;
  logic   pick_a;
  logic [1:0] rank_a, rank_b;

  function automatic logic permitted(input logic [2:0] code);
    return (code == 3'b101) || (code == 3'b011) || (code == 3'b001);
  endfunction

  function automatic logic [1:0] rank(input logic [2:0] code);
    case (code)
      3'b101:  return 2'd3;
      3'b011:  return 2'd2;
      3'b001:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    perm_a = permitted(PRF_A);
    perm_b = permitted(PRF_B);
    rank_a = rank(PRF_A);
    rank_b = rank(PRF_B);
    elig_a = REQ_A & perm_a & ~TOUT_A;
    elig_b = REQ_B & perm_b & ~TOUT_B;
    // Equal ranks go to the side that did not hold the previous grant.
    pick_a = elig_a & (~elig_b | (rank_a > rank_b) | ((rank_a == rank_b) & last_b));
  end

  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      GNT_A     <= 1'b0;
      GNT_B     <= 1'b0;
      DENY_A    <= 1'b0;
      DENY_B    <= 1'b0;
      TOUT_A    <= 1'b0;
      TOUT_B    <= 1'b0;
      BUSY      <= 1'b0;
      OWNER_PRF <= 3'b000;
      CNT       <= 8'd0;
    end else begin
      DENY_A <= REQ_A & ~perm_a;
      DENY_B <= REQ_B & ~perm_b;
      if (!REQ_A) TOUT_A <= 1'b0;
      if (!REQ_B) TOUT_B <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_a) begin
            state     <= GRANT_A;
            GNT_A     <= 1'b1;
            BUSY      <= 1'b1;
            CNT       <= 8'd1;
            OWNER_PRF <= PRF_A;
            last_b    <= 1'b0;
          end else if (elig_b) begin
            state     <= GRANT_B;
            GNT_B     <= 1'b1;
            BUSY      <= 1'b1;
            CNT       <= 8'd1;
            OWNER_PRF <= PRF_B;
            last_b    <= 1'b1;
          end
        end

        GRANT_A: begin
          if (!REQ_A || !perm_a || CNT == CNT_MAX) begin
            state     <= RELEASE;
            GNT_A     <= 1'b0;
            CNT       <= 8'd0;
            OWNER_PRF <= 3'b000;
            if (REQ_A && perm_a) TOUT_A <= 1'b1;
          end else begin
            CNT <= CNT + 8'd1;
          end
        end

        GRANT_B: begin
          if (!REQ_B || !perm_b || CNT == CNT_MAX) begin
            state     <= RELEASE;
            GNT_B     <= 1'b0;
            CNT       <= 8'd0;
            OWNER_PRF <= 3'b000;
            if (REQ_B && perm_b) TOUT_B <= 1'b1;
          end else begin
            CNT <= CNT + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/access_arbiter.md
ACCESS_ARBITER -- requirements
Module: access_arbiter

Interface
REQ-001 SHALL have parameter SESSION_MAX, default 16, meaning the maximum consecutive grant cycles per session (legal range 2..255).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port PRF_A, input, 3, IE01 profile code {CH7,CH6,CH5}.
REQ-005 SHALL have port REQ_A, input, 1, IE01 access request (level).
REQ-006 SHALL have port PRF_B, input, 3, IE02 profile code {CH3,CH2,CH1}.
REQ-007 SHALL have port REQ_B, input, 1, IE02 access request (level).
REQ-008 SHALL have ports GNT_A and GNT_B, output, 1 each, registered grants that are mutually exclusive.
REQ-009 SHALL have ports DENY_A and DENY_B, output, 1 each, registered request-refused flags.
REQ-010 SHALL have ports TOUT_A and TOUT_B, output, 1 each, registered session-expired flags.
REQ-011 SHALL have port BUSY, output, 1, high while the FSM is outside IDLE.
REQ-012 SHALL have port OWNER_PRF, output, 3, profile code latched at grant; 000 when no grant.
REQ-013 SHALL have port CNT, output, 8, grant cycles elapsed in the current session.

Function
REQ-014 Profile decode SHALL be: 101=ADMIN (rank 3), 011=TESTER (rank 2), 001=USER (rank 1), 110=GUEST (rank 0); all other codes are INVALID.
REQ-015 A side SHALL be permitted only for ADMIN, TESTER or USER; GUEST and INVALID are not permitted.
REQ-016 A side SHALL be eligible when REQ=1, it is permitted, and its TOUT flag is 0.
REQ-017 DENY_x SHALL be the value of (REQ_x AND NOT permitted_x) registered one cycle earlier, in every state.
REQ-018 The FSM SHALL have states IDLE, GRANT_A, GRANT_B and RELEASE; BUSY=1 in every state except IDLE.
REQ-019 In IDLE with exactly one side eligible, the FSM SHALL enter that side's GRANT state, so GNT goes high one cycle after REQ is sampled.
REQ-020 In IDLE with both sides eligible, the higher rank SHALL win.
REQ-021 On equal rank, the side not named by the LAST pointer SHALL win; LAST resets to B, so A wins the first tie.
REQ-022 On entering GRANT_x, the block SHALL set CNT=1, OWNER_PRF=PRF_x and LAST=x.
REQ-023 In GRANT_x, CNT SHALL increment by 1 each cycle while REQ_x is high and PRF_x is permitted.
REQ-024 In GRANT_x, a change of PRF_x to another permitted code SHALL NOT alter OWNER_PRF.
REQ-025 In GRANT_x, the FSM SHALL go to RELEASE on REQ_x=0 or PRF_x not permitted; TOUT_x is not set.
REQ-026 In GRANT_x, when CNT=SESSION_MAX with REQ_x still high, the FSM SHALL go to RELEASE and set TOUT_x=1; maximum GNT width is SESSION_MAX cycles.
REQ-027 RELEASE SHALL last exactly one cycle with GNT_A=GNT_B=0, CNT=0 and OWNER_PRF=000, then return to IDLE.
REQ-028 TOUT_x SHALL clear on the first cycle REQ_x is sampled low; a timed-out side is ineligible until it clears.
REQ-029 The non-owner's request SHALL be ignored during a grant; there is no preemption, and it is arbitrated on the next IDLE.
REQ-030 GNT_A and GNT_B SHALL never be high in the same cycle, and there SHALL be at least one cycle between consecutive grants.

Reset
REQ-031 With RST high at a rising edge, the next state SHALL be IDLE, with GNT_x, DENY_x, TOUT_x, BUSY, CNT and OWNER_PRF all 0 and LAST=B.
REQ-032 Reset SHALL override all other inputs, including mid-grant; REQ inputs are ignored during that cycle.

Verification
REQ-033 REQ_A=1, PRF_A=011, B idle -> GNT_A=1 next cycle, OWNER_PRF=011, CNT counts 1,2,3...; drop REQ_A -> GNT_A=0 next cycle, one RELEASE cycle, then IDLE.
REQ-034 REQ_A=1 with PRF_A=001 and REQ_B=1 with PRF_B=101, simultaneously -> GNT_B wins; after B releases, GNT_A asserts after the RELEASE cycle.
REQ-035 Both sides request with PRF=011 repeatedly and each drops after 3 cycles -> grants alternate A, B, A, B starting with A.
REQ-036 REQ_B=1 with PRF_B=110, then PRF_B=111 -> DENY_B=1 one cycle later in each case, GNT_B stays 0, and A is still serviceable.
REQ-037 SESSION_MAX=4 and REQ_A held high -> GNT_A high for exactly 4 cycles, then TOUT_A=1 and no regrant to A until REQ_A drops; a waiting B is granted.
REQ-038 RST pulsed during GRANT_B at CNT=5 -> all outputs 0 next cycle; a subsequent tie grants A first.
